// File: rtl/meas_sched_if.sv
// Control/status bundle between the measurement scheduler, its host and the ADC sequencer.
interface meas_sched_if #(
  parameter int PER_W = 16
);
  logic             atpg;
  logic             en;
  logic [PER_W-1:0] period;
  logic             sw_req;
  logic             ovr_clr;
  logic [2:0]       meas_state;
  logic             meas_eoc_p;
  logic             meas_eop;
  logic             trig;
  logic             busy;
  logic             done_p;
  logic             timeout_p;
  logic             overrun;

  modport master (
    output atpg, en, period, sw_req, ovr_clr, meas_state, meas_eoc_p, meas_eop,
    input  trig, busy, done_p, timeout_p, overrun
  );

  modport slave (
    input  atpg, en, period, sw_req, ovr_clr, meas_state, meas_eoc_p, meas_eop,
    output trig, busy, done_p, timeout_p, overrun
  );
endinterface

// File: rtl/meas_sched.sv
// Measurement scheduler: issues periodic or software-requested sequence starts,
// watches the running sequence with a watchdog and flags dropped requests.
module meas_sched #(
  parameter int TO_CYC = 255,
  parameter int PER_W  = 16
) (
  input logic         prim_clk,
  input logic         prim_rstb,
  meas_sched_if.slave bus
);

  localparam int WD_W = (TO_CYC < 1) ? 1 : $clog2(TO_CYC + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TO_CYC);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_START,
    ST_RUN
  } state_t;

  state_t           state_reg, state_next;
  logic [PER_W-1:0] pcnt_reg, pcnt_next;
  logic [WD_W-1:0]  wdog_reg, wdog_next;
  logic             pend_reg, pend_next;
  logic             trig_reg, trig_next;
  logic             done_reg, done_next;
  logic             tmo_reg, tmo_next;
  logic             ovr_reg, ovr_next;

  logic [PER_W-1:0] per_m1;
  logic [PER_W-1:0] per_m2;
  logic             seq_idle;
  logic             seq_last;
  logic             evt;
  logic             fin;
  logic             wd_exp;
  logic             fire;
  logic             queue;
  logic             pend_clr;
  logic             ovr_set;

  // per_m2 is reloaded at trig: the START cycle and the registered trig
  // account for the other two cycles, so trig-to-trig spacing equals period.
  assign per_m1   = (bus.period == '0) ? '0 : bus.period - PER_W'(1);
  assign per_m2   = (per_m1 == '0) ? '0 : per_m1 - PER_W'(1);
  assign seq_idle = (bus.meas_state == 3'b000);
  assign seq_last = (bus.meas_state == 3'b100);
  assign evt      = bus.meas_eoc_p | bus.meas_eop;
  assign fin      = (state_reg == ST_RUN) && bus.meas_eop && seq_last;
  assign wd_exp   = (state_reg == ST_RUN) && (wdog_reg == '0) && !evt;
  assign fire     = (state_reg == ST_START) && seq_idle && !bus.atpg;

  // A request that cannot go straight to START is queued in pend.
  assign queue    = bus.sw_req && ((state_reg == ST_START) || (state_reg == ST_RUN) || bus.atpg);
  assign pend_clr = fire || wd_exp;
  assign ovr_set  = (queue && pend_reg && !pend_clr) ||
                    ((state_reg == ST_RUN) && bus.en && (pcnt_reg == '0));

  always_comb begin
    state_next = state_reg;
    pcnt_next  = pcnt_reg;
    wdog_next  = wdog_reg;
    pend_next  = (pend_reg && !pend_clr) || queue;
    ovr_next   = ovr_set || (ovr_reg && !bus.ovr_clr);
    trig_next  = fire;
    done_next  = fin;
    tmo_next   = wd_exp && !fin;

    case (state_reg)
      ST_IDLE: begin
        if (!bus.atpg) begin
          if (bus.sw_req || pend_reg) begin
            state_next = ST_START;
          end else if (bus.en) begin
            state_next = ST_WAIT;
            pcnt_next  = per_m1;
          end
        end
      end
      ST_WAIT: begin
        if (!bus.atpg) begin
          if (bus.sw_req || pend_reg) begin
            state_next = ST_START;
          end else if (!bus.en) begin
            state_next = ST_IDLE;
          end else if (pcnt_reg == '0) begin
            state_next = ST_START;
          end else begin
            pcnt_next = pcnt_reg - PER_W'(1);
          end
        end
      end
      ST_START: begin
        if (fire) begin
          state_next = ST_RUN;
          pcnt_next  = per_m2;
          wdog_next  = WD_LOAD;
        end
      end
      ST_RUN: begin
        // The period timer keeps running so WAIT after completion resumes it.
        if (bus.en) begin
          pcnt_next = (pcnt_reg == '0) ? per_m1 : pcnt_reg - PER_W'(1);
        end
        if (evt) begin
          wdog_next = WD_LOAD;
        end else if (wdog_reg != '0) begin
          wdog_next = wdog_reg - WD_W'(1);
        end
        if (fin) begin
          if (pend_reg || bus.sw_req) begin
            state_next = ST_START;
          end else if (bus.en) begin
            state_next = ST_WAIT;
          end else begin
            state_next = ST_IDLE;
          end
        end else if (wd_exp) begin
          state_next = bus.sw_req ? ST_START : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge prim_clk or negedge prim_rstb) begin
    if (!prim_rstb) begin
      state_reg <= ST_IDLE;
      pcnt_reg  <= '0;
      wdog_reg  <= '0;
      pend_reg  <= 1'b0;
      trig_reg  <= 1'b0;
      done_reg  <= 1'b0;
      tmo_reg   <= 1'b0;
      ovr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pcnt_reg  <= pcnt_next;
      wdog_reg  <= wdog_next;
      pend_reg  <= pend_next;
      trig_reg  <= trig_next;
      done_reg  <= done_next;
      tmo_reg   <= tmo_next;
      ovr_reg   <= ovr_next;
    end
  end

  assign bus.trig      = trig_reg;
  assign bus.busy      = (state_reg == ST_START) || (state_reg == ST_RUN);
  assign bus.done_p    = done_reg;
  assign bus.timeout_p = tmo_reg;
  assign bus.overrun   = ovr_reg;

endmodule

// File: tb/tb_meas_sched.sv
// Directed bench for meas_sched with a small sequencer model driven per clock step.
module tb_meas_sched;

  logic prim_clk = 1'b0;
  logic prim_rstb;

  always #5 prim_clk = ~prim_clk;

  meas_sched_if #(.PER_W(16)) bus ();

  meas_sched #(.TO_CYC(255), .PER_W(16)) dut (
    .prim_clk  (prim_clk),
    .prim_rstb (prim_rstb),
    .bus       (bus.slave)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit model_en = 0;
  int seq_len = 12;
  int seq_cnt = 0;
  int trig_cnt = 0;
  int done_cnt = 0;
  int to_cnt = 0;
  int trig_q[$];

  // Advance one clock, sample outputs 1 time unit later, update the sequencer model.
  task automatic step();
    @(posedge prim_clk);
    #1;
    cyc++;
    if (bus.trig === 1'b1) begin
      trig_cnt++;
      trig_q.push_back(cyc);
    end
    if (bus.done_p === 1'b1) done_cnt++;
    if (bus.timeout_p === 1'b1) to_cnt++;
    if (model_en) begin
      bus.meas_eop   = 1'b0;
      bus.meas_eoc_p = 1'b0;
      if (bus.trig === 1'b1) seq_cnt = seq_len;
      if (seq_cnt > 0) begin
        seq_cnt--;
        bus.meas_state = (seq_cnt == 0) ? 3'b100 : 3'b001;
        bus.meas_eop   = (seq_cnt == 0);
        bus.meas_eoc_p = (seq_cnt % 4 == 1);
      end else begin
        bus.meas_state = 3'b000;
      end
    end
  endtask

  task automatic clr_counts();
    trig_cnt = 0;
    done_cnt = 0;
    to_cnt   = 0;
    trig_q.delete();
  endtask

  task automatic do_reset();
    prim_rstb      = 1'b0;
    bus.atpg       = 1'b0;
    bus.en         = 1'b0;
    bus.period     = '0;
    bus.sw_req     = 1'b0;
    bus.ovr_clr    = 1'b0;
    bus.meas_state = 3'b000;
    bus.meas_eoc_p = 1'b0;
    bus.meas_eop   = 1'b0;
    model_en       = 0;
    seq_cnt        = 0;
    repeat (3) @(posedge prim_clk);
    @(negedge prim_clk);
    prim_rstb = 1'b1;
    clr_counts();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++; if (bus.trig !== 1'b0) begin n_fail++; $display("FAIL rst_trig: got %b want 0", bus.trig); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_chk++; if (bus.done_p !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus.done_p); end
    n_chk++; if (bus.timeout_p !== 1'b0) begin n_fail++; $display("FAIL rst_tmo: got %b want 0", bus.timeout_p); end
    n_chk++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL rst_ovr: got %b want 0", bus.overrun); end
    repeat (5) step();
    n_chk++; if (bus.busy !== 1'b0 || trig_cnt != 0) begin n_fail++; $display("FAIL rst_nostart: busy=%b trigs=%0d want 0/0", bus.busy, trig_cnt); end
    $display("test_reset: outputs idle after reset");
  endtask

  task automatic test_sw_latency();
    do_reset();
    step();
    bus.sw_req = 1'b1;
    step();
    bus.sw_req = 1'b0;
    n_chk++; if (bus.busy !== 1'b1 || bus.trig !== 1'b0) begin n_fail++; $display("FAIL lat_n1: busy=%b trig=%b want 1/0", bus.busy, bus.trig); end
    step();
    n_chk++; if (bus.trig !== 1'b1) begin n_fail++; $display("FAIL lat_n2: trig=%b want 1", bus.trig); end
    step();
    n_chk++; if (bus.trig !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL lat_n3: trig=%b busy=%b want 0/1", bus.trig, bus.busy); end
    bus.meas_state = 3'b100;
    bus.meas_eop   = 1'b1;
    step();
    bus.meas_state = 3'b000;
    bus.meas_eop   = 1'b0;
    n_chk++; if (bus.done_p !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL lat_done: done=%b busy=%b want 1/0", bus.done_p, bus.busy); end
    step();
    n_chk++; if (bus.done_p !== 1'b0 || trig_cnt != 1) begin n_fail++; $display("FAIL lat_single: done=%b trigs=%0d want 0/1", bus.done_p, trig_cnt); end
    $display("test_sw_latency: sw_req -> trig two cycles later");
  endtask

  task automatic test_periodic();
    int c0;
    int first;
    do_reset();
    model_en   = 1;
    seq_len    = 12;
    bus.period = 16'd20;
    c0 = cyc;
    bus.en = 1'b1;
    for (int i = 0; i < 40 && trig_cnt == 0; i++) step();
    first = (trig_q.size() > 0) ? trig_q[0] : -1;
    n_chk++; if (first != c0 + 22) begin n_fail++; $display("FAIL per_first: trig at %0d want %0d", first, c0 + 22); end
    repeat (105) step();
    n_chk++; if (trig_cnt != 6) begin n_fail++; $display("FAIL per_count: trigs=%0d want 6", trig_cnt); end
    n_chk++; if (done_cnt != 5) begin n_fail++; $display("FAIL per_done: dones=%0d want 5", done_cnt); end
    for (int i = 1; i < trig_q.size(); i++) begin
      n_chk++;
      if (trig_q[i] - trig_q[i-1] != 20) begin
        n_fail++;
        $display("FAIL per_gap: gap %0d = %0d want 20", i, trig_q[i] - trig_q[i-1]);
      end
    end
    n_chk++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL per_ovr: overrun=%b want 0", bus.overrun); end
    bus.en = 1'b0;
    repeat (30) step();
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL per_stop: busy=%b want 0", bus.busy); end
    $display("test_periodic: %0d trigs spaced 20 cycles", trig_cnt);
  endtask

  task automatic test_overrun();
    do_reset();
    model_en   = 1;
    seq_len    = 12;
    bus.period = 16'd5;
    bus.en     = 1'b1;
    for (int i = 0; i < 40 && trig_cnt == 0; i++) step();
    for (int i = 0; i < 30 && done_cnt == 0; i++) step();
    n_chk++; if (done_cnt != 1 || bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: dones=%0d overrun=%b want 1/1", done_cnt, bus.overrun); end
    bus.en = 1'b0;
    repeat (40) step();
    n_chk++; if (bus.busy !== 1'b0 || bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: busy=%b overrun=%b want 0/1", bus.busy, bus.overrun); end
    bus.ovr_clr = 1'b1;
    step();
    bus.ovr_clr = 1'b0;
    n_chk++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clr: overrun=%b want 0", bus.overrun); end
    $display("test_overrun: period 5 with 12-cycle sequence flags overrun");
  endtask

  task automatic test_pend();
    do_reset();
    model_en = 1;
    seq_len  = 12;
    bus.sw_req = 1'b1;
    step();
    bus.sw_req = 1'b0;
    step();
    n_chk++; if (trig_cnt != 1) begin n_fail++; $display("FAIL pend_trig1: trigs=%0d want 1", trig_cnt); end
    repeat (2) step();
    bus.sw_req = 1'b1;
    step();
    bus.sw_req = 1'b0;
    n_chk++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL pend_first: overrun=%b want 0", bus.overrun); end
    step();
    bus.sw_req  = 1'b1;
    bus.ovr_clr = 1'b1;
    step();
    bus.sw_req  = 1'b0;
    bus.ovr_clr = 1'b0;
    n_chk++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL pend_setwins: overrun=%b want 1", bus.overrun); end
    bus.ovr_clr = 1'b1;
    step();
    bus.ovr_clr = 1'b0;
    n_chk++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL pend_clr: overrun=%b want 0", bus.overrun); end
    for (int i = 0; i < 20 && done_cnt == 0; i++) step();
    n_chk++; if (done_cnt != 1 || bus.busy !== 1'b1 || bus.trig !== 1'b0) begin n_fail++; $display("FAIL pend_done: dones=%0d busy=%b trig=%b want 1/1/0", done_cnt, bus.busy, bus.trig); end
    step();
    n_chk++; if (bus.trig !== 1'b1) begin n_fail++; $display("FAIL pend_retrig: trig=%b want 1", bus.trig); end
    repeat (30) step();
    n_chk++; if (trig_cnt != 2 || done_cnt != 2 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL pend_final: trigs=%0d dones=%0d busy=%b want 2/2/0", trig_cnt, done_cnt, bus.busy); end
    $display("test_pend: queued request served once, extra one dropped");
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.sw_req = 1'b1;
    step();
    bus.sw_req = 1'b0;
    step();
    bus.meas_state = 3'b001;
    step();
    bus.meas_state = 3'b100;
    bus.meas_eop   = 1'b1;
    bus.sw_req     = 1'b1;
    step();
    bus.meas_state = 3'b000;
    bus.meas_eop   = 1'b0;
    bus.sw_req     = 1'b0;
    n_chk++; if (bus.done_p !== 1'b1 || bus.busy !== 1'b1 || bus.overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_done: done=%b busy=%b ovr=%b want 1/1/0", bus.done_p, bus.busy, bus.overrun); end
    step();
    n_chk++; if (bus.trig !== 1'b1) begin n_fail++; $display("FAIL b2b_trig: trig=%b want 1", bus.trig); end
    bus.meas_state = 3'b100;
    bus.meas_eop   = 1'b1;
    step();
    bus.meas_state = 3'b000;
    bus.meas_eop   = 1'b0;
    n_chk++; if (bus.busy !== 1'b0 || trig_cnt != 2) begin n_fail++; $display("FAIL b2b_end: busy=%b trigs=%0d want 0/2", bus.busy, trig_cnt); end
    $display("test_back_to_back: request at completion restarts sequence");
  endtask

  task automatic test_timeout();
    do_reset();
    bus.sw_req = 1'b1;
    step();
    bus.sw_req = 1'b0;
    step();
    bus.meas_state = 3'b001;
    repeat (99) step();
    bus.meas_eoc_p = 1'b1;
    step();
    bus.meas_eoc_p = 1'b0;
    repeat (255) step();
    n_chk++; if (to_cnt != 0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL tmo_early: timeouts=%0d busy=%b want 0/1", to_cnt, bus.busy); end
    step();
    n_chk++; if (bus.timeout_p !== 1'b1 || bus.busy !== 1'b0 || bus.done_p !== 1'b0) begin n_fail++; $display("FAIL tmo_fire: tmo=%b busy=%b done=%b want 1/0/0", bus.timeout_p, bus.busy, bus.done_p); end
    step();
    n_chk++; if (bus.timeout_p !== 1'b0 || to_cnt != 1 || done_cnt != 0) begin n_fail++; $display("FAIL tmo_pulse: tmo=%b timeouts=%0d dones=%0d want 0/1/0", bus.timeout_p, to_cnt, done_cnt); end
    bus.meas_state = 3'b000;
    bus.sw_req = 1'b1;
    step();
    bus.sw_req = 1'b0;
    step();
    bus.meas_state = 3'b001;
    repeat (255) step();
    bus.meas_state = 3'b100;
    bus.meas_eop   = 1'b1;
    step();
    bus.meas_state = 3'b000;
    bus.meas_eop   = 1'b0;
    n_chk++; if (bus.done_p !== 1'b1 || bus.timeout_p !== 1'b0) begin n_fail++; $display("FAIL tmo_tie: done=%b tmo=%b want 1/0", bus.done_p, bus.timeout_p); end
    step();
    n_chk++; if (to_cnt != 1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL tmo_tie_end: timeouts=%0d busy=%b want 1/0", to_cnt, bus.busy); end
    $display("test_timeout: watchdog fires after TO_CYC+1 idle cycles");
  endtask

  task automatic test_atpg();
    do_reset();
    model_en   = 1;
    seq_len    = 12;
    bus.atpg   = 1'b1;
    bus.en     = 1'b1;
    bus.period = 16'd10;
    bus.sw_req = 1'b1;
    step();
    bus.sw_req = 1'b0;
    repeat (99) step();
    n_chk++; if (trig_cnt != 0 || bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin n_fail++; $display("FAIL atpg_block: trigs=%0d busy=%b ovr=%b want 0/0/0", trig_cnt, bus.busy, bus.overrun); end
    bus.atpg = 1'b0;
    step();
    n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL atpg_start: busy=%b want 1", bus.busy); end
    step();
    n_chk++; if (bus.trig !== 1'b1) begin n_fail++; $display("FAIL atpg_trig: trig=%b want 1", bus.trig); end
    bus.en = 1'b0;
    repeat (30) step();
    n_chk++; if (bus.busy !== 1'b0 || done_cnt != 1) begin n_fail++; $display("FAIL atpg_end: busy=%b dones=%0d want 0/1", bus.busy, done_cnt); end
    $display("test_atpg: starts held off in test mode, released after");
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    model_en = 1;
    seq_len  = 12;
    bus.sw_req = 1'b1;
    step();
    bus.sw_req = 1'b0;
    step();
    bus.sw_req = 1'b1;
    step();
    step();
    bus.sw_req = 1'b0;
    n_chk++; if (bus.busy !== 1'b1 || bus.overrun !== 1'b1) begin n_fail++; $display("FAIL rmr_pre: busy=%b ovr=%b want 1/1", bus.busy, bus.overrun); end
    #2;
    prim_rstb = 1'b0;
    #1;
    n_chk++; if (bus.busy !== 1'b0 || bus.overrun !== 1'b0 || bus.done_p !== 1'b0 || bus.timeout_p !== 1'b0) begin n_fail++; $display("FAIL rmr_async: busy=%b ovr=%b done=%b tmo=%b want 0/0/0/0", bus.busy, bus.overrun, bus.done_p, bus.timeout_p); end
    model_en = 0;
    seq_cnt  = 0;
    bus.meas_state = 3'b000;
    bus.meas_eop   = 1'b0;
    bus.meas_eoc_p = 1'b0;
    @(negedge prim_clk);
    prim_rstb = 1'b1;
    clr_counts();
    repeat (20) step();
    n_chk++; if (trig_cnt != 0 || done_cnt != 0 || to_cnt != 0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmr_after: trigs=%0d dones=%0d tmos=%0d busy=%b want 0/0/0/0", trig_cnt, done_cnt, to_cnt, bus.busy); end
    $display("test_reset_mid_run: reset aborts sequence silently");
  endtask

  initial begin
    test_reset();
    test_sw_latency();
    test_periodic();
    test_overrun();
    test_pend();
    test_back_to_back();
    test_timeout();
    test_atpg();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/meas_sched.md
MEAS_SCHED -- requirements
Module: meas_sched

Interface
REQ-001 Parameter TO_CYC, default 255, is the number of cycles allowed between consecutive ADC events before a timeout.
REQ-002 Parameter PER_W, default 16, is the width of the period input.
REQ-003 prim_clk  input  1  is the block clock.
REQ-004 prim_rstb  input  1  is the reset: asynchronous, active-low.
REQ-005 atpg  input  1  is test mode; when high it blocks all new measurement starts.
REQ-006 en  input  1  enables periodic measurement.
REQ-007 period  input  PER_W  is the number of cycles from one trig to the next periodic trig; the value 0 is treated as 1.
REQ-008 sw_req  input  1  is a single-cycle software measurement request.
REQ-009 ovr_clr  input  1  clears the overrun flag.
REQ-010 meas_state  input  3  is the sequencer state; 3'b000 means idle and 3'b100 means last step.
REQ-011 meas_eoc_p  input  1  is the sequencer's per-conversion pulse.
REQ-012 meas_eop  input  1  is the sequencer's per-step end pulse.
REQ-013 trig  output  1  is a one-cycle sequence start pulse, registered.
REQ-014 busy  output  1  is high in the START and RUN states.
REQ-015 done_p  output  1  pulses for one cycle when a sequence completes.
REQ-016 timeout_p  output  1  pulses for one cycle when the watchdog expires.
REQ-017 overrun  output  1  is a sticky flag for missed or dropped requests.

Function
REQ-018 The FSM shall have the states IDLE, WAIT, START and RUN; all outputs shall be registered except busy, which decodes the state.
REQ-019 IDLE: on sw_req or pend, go to START; otherwise, on en, go to WAIT and load pcnt = max(period,1)-1.
REQ-020 WAIT: pcnt decrements each cycle; at pcnt == 0 go to START; on sw_req go to START immediately (priority over the timer); on en low (and no sw_req) return to IDLE.
REQ-021 START: hold until meas_state == 3'b000, then assert trig for exactly one cycle, clear pend, load wdog = TO_CYC, and go to RUN.
REQ-022 Latency: sw_req in IDLE at cycle n shall produce trig at cycle n+2 when meas_state == 0 (one cycle to START, one cycle for the registered pulse).
REQ-023 RUN watchdog: wdog reloads to TO_CYC on meas_eoc_p or meas_eop and decrements otherwise.
REQ-024 RUN completion: meas_eop while meas_state == 3'b100 shall give done_p the next cycle.
REQ-025 After completion the FSM shall go to START if pend is set, else to WAIT if en is high (loading pcnt), else to IDLE.
REQ-026 RUN timeout: wdog == 0 with no event shall give timeout_p the next cycle, clear pend, and go to IDLE; done_p shall not be asserted.
REQ-027 sw_req in RUN or START shall set pend; sw_req while pend is already set shall set overrun, and the request is dropped.
REQ-028 Periodic timer expiry while in RUN (pcnt is free-running from the last trig when en is high) shall set overrun and shall not queue a start.
REQ-029 If overrun set and ovr_clr occur in the same cycle, set wins.
REQ-030 Completion and timeout conditions in the same cycle: completion wins.
REQ-031 en going low in RUN shall not abort the sequence; the FSM returns to IDLE after done.
REQ-032 atpg high: trig shall be forced to 0; IDLE, WAIT and START shall hold state; RUN shall continue to be monitored.
REQ-033 sw_req arriving in the same cycle the FSM leaves RUN for IDLE or WAIT shall be treated as pend, so START is entered.

Reset
REQ-034 On prim_rstb low: state = IDLE, pcnt = 0, wdog = 0, pend = 0, trig = 0, done_p = 0, timeout_p = 0, overrun = 0, busy = 0.
REQ-035 Reset asserted mid-RUN shall return the FSM to IDLE immediately without pulsing done_p or timeout_p.
REQ-036 After reset release, the first start shall require sw_req or en.

Verification
REQ-037 en=0, sw_req pulse at cycle 10, meas_state=0 -> trig=1 at cycle 12 only; busy high from cycle 11.
REQ-038 en=1, period=20, sequence model completes in 12 cycles -> trig exactly every 20 cycles; done_p once per sequence; overrun stays 0.
REQ-039 en=1, period=5, sequence takes 12 cycles -> overrun=1 after the first sequence; ovr_clr pulse -> 0; set and clear in the same cycle -> overrun remains 1.
REQ-040 RUN with no meas_eoc_p or meas_eop for TO_CYC+1 cycles -> timeout_p single pulse, FSM in IDLE, no done_p.
REQ-041 Two sw_req pulses during RUN -> pend served by one trig after done_p; second request sets overrun.
REQ-042 atpg=1 with sw_req and en -> trig stays 0 for 100 cycles; after atpg drops -> trig issued.
